fpc_rr_tag_sched: RTL

- Scheduler feeding the read-request multiplexer (the fpc_rr_mux instance).
- Owns the per-channel pool of low tag bits and a shared completion-buffer credit budget.
- Presents rr_valid / rr_tag_low per channel only when a free tag and a reserved credit exist.
- Recycles tags and credits when the completion unit reports a request fully returned.

---
 rtl/fpc_pkg.sv | 10 +
 rtl/fpc_rr_arb4.sv | 37 +++
 rtl/fpc_rr_tag_sched.sv | 115 +++++++++++
 3 files changed

// File: rtl/fpc_pkg.sv
// rtl/fpc_pkg.sv - shared tag field layout for the read-request path
// Full tag is {2'b0, chan[1:0], 1'b0, tag_low[2:0]}.
package fpc_pkg;
   localparam int CHAN_W       = 2;
   localparam int TAG_W        = 8;
   localparam int TAG_CHAN_LSB = 4;
   localparam int TAG_CHAN_W   = 2;
   localparam int TAG_ZERO_BIT = 3;
   localparam int TAG_HI_LSB   = 6;
endpackage

// File: rtl/fpc_rr_arb4.sv
// rtl/fpc_rr_arb4.sv - 4-way round-robin arbiter with rotating pointer
// Pure combinational; the caller owns the pointer register.
module fpc_rr_arb4
   import fpc_pkg::*;
(
   input  logic [3:0]        request,
   input  logic              enable_grant,
   input  logic [CHAN_W-1:0] ptr,
   output logic [3:0]        grant,
   output logic [CHAN_W-1:0] ptr_next
);

   logic              found;
   logic [CHAN_W-1:0] idx;
   logic [CHAN_W-1:0] win;

   always_comb begin
      grant    = '0;
      ptr_next = ptr;
      found    = 1'b0;
      idx      = '0;
      win      = '0;
      // Search starts at the pointer so the last winner gets lowest priority.
      for (int k = 0; k < 4; k++) begin
         idx = ptr + CHAN_W'(k);
         if (!found && request[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
      if (enable_grant && found) begin
         grant[win] = 1'b1;
         ptr_next   = win + CHAN_W'(1);
      end
   end

endmodule

// File: rtl/fpc_rr_tag_sched.sv
// rtl/fpc_rr_tag_sched.sv - per-channel tag pools and shared credit budget
// Offers one tag per channel to the read-request mux; recycles on completion.
module fpc_rr_tag_sched
   import fpc_pkg::*;
#(
   parameter int               NCHAN         = 4,
   parameter int               NBITS_TAG_LOW = 3,
   parameter logic [NCHAN-1:0] ENABLE        = 4'b0001,
   parameter int               CREDITS       = 16
) (
   input  logic                           clock,
   input  logic                           reset_n,
   output logic [NCHAN-1:0]               rr_valid,
   input  logic [NCHAN-1:0]               rr_ready,
   output logic [NCHAN*NBITS_TAG_LOW-1:0] rr_tag_low,
   input  logic                           cpl_done,
   input  logic [TAG_W-1:0]               cpl_tag,
   output logic [5:0]                     credits_free,
   output logic                           idle,
   output logic                           err
);

   localparam int NTAG = 1 << NBITS_TAG_LOW;

   logic [5:0]               credits_q, credits_d;
   logic                     err_q, err_d;
   logic [CHAN_W-1:0]        ptr_q, ptr_d, ptr_next;
   logic [NCHAN-1:0]         request, grant, accept, outstanding, pool_idle;
   logic                     grant_any;
   logic [CHAN_W-1:0]        cpl_chan;
   logic [NBITS_TAG_LOW-1:0] cpl_low;
   logic                     cpl_fmt_ok, cpl_ret;

   assign cpl_chan   = cpl_tag[TAG_CHAN_LSB +: TAG_CHAN_W];
   assign cpl_low    = cpl_tag[NBITS_TAG_LOW-1:0];
   assign cpl_fmt_ok = (cpl_tag[TAG_W-1:TAG_HI_LSB] == '0) && !cpl_tag[TAG_ZERO_BIT];
   // A tag offered and accepted this cycle still reads free, so its completion is rejected.
   assign cpl_ret    = cpl_done && cpl_fmt_ok && ENABLE[cpl_chan] && outstanding[cpl_chan];

   fpc_rr_arb4 u_arb (
      .request      (request),
      .enable_grant (credits_q != '0),
      .ptr          (ptr_q),
      .grant        (grant),
      .ptr_next     (ptr_next)
   );

   assign grant_any = |grant;

   for (genvar i = 0; i < NCHAN; i++) begin : g_chan
      logic [NTAG-1:0]          free_q, free_d;
      logic                     resv_q, resv_d;
      logic                     valid_q, valid_d;
      logic [NBITS_TAG_LOW-1:0] tag_q, tag_d;
      logic [NTAG-1:0]          acc_mask, ret_mask;

      assign request[i]     = ENABLE[i] && !resv_q && (free_q != '0);
      assign accept[i]      = valid_q && rr_ready[i];
      assign outstanding[i] = !free_q[cpl_low];
      assign pool_idle[i]   = (free_q == '1) && !resv_q;
      assign rr_valid[i]    = valid_q;
      assign rr_tag_low[i*NBITS_TAG_LOW +: NBITS_TAG_LOW] = tag_q;

      always_comb begin
         tag_d    = '0;
         acc_mask = '0;
         ret_mask = '0;
         for (int t = NTAG - 1; t >= 0; t--) begin
            if (free_q[t]) tag_d = NBITS_TAG_LOW'(t);
         end
         if (accept[i]) acc_mask[tag_q] = 1'b1;
         if (cpl_ret && (cpl_chan == CHAN_W'(i))) ret_mask[cpl_low] = 1'b1;
         free_d  = (free_q & ~acc_mask) | ret_mask;
         resv_d  = (resv_q || grant[i]) && !accept[i];
         valid_d = resv_q && (free_q != '0) && !accept[i];
      end

      always_ff @(posedge clock or negedge reset_n) begin
         if (!reset_n) begin
            free_q  <= '1;
            resv_q  <= 1'b0;
            valid_q <= 1'b0;
            tag_q   <= '0;
         end else begin
            free_q  <= free_d;
            resv_q  <= resv_d;
            valid_q <= valid_d;
            tag_q   <= tag_d;
         end
      end
   end

   always_comb begin
      ptr_d     = ptr_next;
      credits_d = credits_q - {5'b0, grant_any} + {5'b0, cpl_ret};
      err_d     = err_q || (cpl_done && !cpl_ret);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         credits_q <= 6'(CREDITS);
         err_q     <= 1'b0;
         ptr_q     <= '0;
      end else begin
         credits_q <= credits_d;
         err_q     <= err_d;
         ptr_q     <= ptr_d;
      end
   end

   assign credits_free = credits_q;
   assign err          = err_q;
   assign idle         = &(pool_idle | ~ENABLE);

endmodule
